// File: rtl/gaus_pkg.sv
// Shared types and constants for the gaussian window hold stage.
// State encoding, default address constants and row slicing helper.
package gaus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } holdState_t;

    localparam int DEF_STARTADDRESS = 770;
    localparam int DEF_ENDADDRESS   = 2097152;
    localparam int DEF_PIXW         = 24;

    // Bit offset of a row inside a flattened window; row 0 sits in the LSBs.
    function automatic int rowOffset(input int row, input int roww);
        return row * roww;
    endfunction

endpackage

// File: rtl/window_beat_counter.sv
// Frame sequencer: pause, capture-beat phase, pixel address and frame end.
// Emits one strobe per BEATS enabled cycles while running.
module window_beat_counter
    import gaus_pkg::*;
#(
    parameter int PAUSE        = 1,
    parameter int BEATS        = 4,
    parameter int COUNTSTEP    = 2,
    parameter int STARTADDRESS = DEF_STARTADDRESS,
    parameter int ENDADDRESS   = DEF_ENDADDRESS,
    parameter int PIXW         = DEF_PIXW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            HoldEn,
    output logic            strobe,
    output logic [PIXW-1:0] pix,
    output logic            busy,
    output logic            done
);

    localparam int PHW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WCW = (PAUSE > 1) ? $clog2(PAUSE) : 1;
    localparam logic [PHW-1:0] LASTPHASE = PHW'(BEATS - 1);
    localparam logic [WCW-1:0] LASTWAIT  = WCW'((PAUSE > 0) ? PAUSE - 1 : 0);
    localparam logic [PIXW:0]  ENDLIM    = (PIXW + 1)'(ENDADDRESS);
    localparam logic [PIXW:0]  STEP      = (PIXW + 1)'(COUNTSTEP);
    localparam logic [PIXW-1:0] START    = PIXW'(STARTADDRESS);

    holdState_t state;
    holdState_t nextState;
    logic [PHW-1:0] phase;
    logic [WCW-1:0] waitCnt;
    logic [PIXW:0]  nextSum;
    logic           atEnd;

    // Widened sum so the frame-end test sees a carry out of the address.
    assign nextSum = {1'b0, pix} + STEP;
    assign atEnd   = (nextSum >= ENDLIM);
    assign strobe  = (state == RUN) && HoldEn && (phase == LASTPHASE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (HoldEn) begin
                    nextState = (PAUSE == 0) ? RUN : WAIT;
                end
            end
            WAIT: begin
                if (waitCnt == LASTWAIT) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (strobe && atEnd) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if (!HoldEn) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        if ((state == WAIT) || (state == RUN)) begin
            busy = 1'b1;
        end
        if (state == DONE) begin
            done = 1'b1;
        end
    end

    // Pause counter, beat phase and pixel address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase   <= '0;
            waitCnt <= '0;
            pix     <= START;
        end else begin
            unique case (state)
                IDLE: begin
                    if (HoldEn) begin
                        pix     <= START;
                        waitCnt <= '0;
                        phase   <= '0;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt + 1'b1;
                    phase   <= '0;
                end
                RUN: begin
                    if (HoldEn) begin
                        phase <= (phase == LASTPHASE) ? '0 : phase + 1'b1;
                    end
                    if (strobe) begin
                        pix <= nextSum[PIXW-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/gaus_window_hold.sv
// Captures a ROWS x ROWW window per beat strobe into a 2-deep hold queue
// and presents it downstream over a valid/ready handshake.
module gaus_window_hold
    import gaus_pkg::*;
#(
    parameter int ROWS         = 5,
    parameter int ROWW         = 40,
    parameter int STARTADDRESS = DEF_STARTADDRESS,
    parameter int ENDADDRESS   = DEF_ENDADDRESS,
    parameter int BEATS        = 4,
    parameter int PAUSE        = 1,
    parameter int COUNTSTEP    = 2,
    parameter int PIXW         = DEF_PIXW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 HoldEn,
    input  logic [ROWS*ROWW-1:0] ShiftIn,
    output logic [ROWS*ROWW-1:0] HoldOut,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PIXW-1:0]      out_pixel,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    input  logic                 clear_ovf
);

    localparam int W = ROWS * ROWW;

    logic            strobe;
    logic [PIXW-1:0] pix;
    logic [W-1:0]    skidData;
    logic [PIXW-1:0] skidPix;
    logic [1:0]      count;
    logic            push;
    logic            pop;
    logic            dropEvt;

    window_beat_counter #(
        .PAUSE        (PAUSE),
        .BEATS        (BEATS),
        .COUNTSTEP    (COUNTSTEP),
        .STARTADDRESS (STARTADDRESS),
        .ENDADDRESS   (ENDADDRESS),
        .PIXW         (PIXW)
    ) beatCounter (
        .clk    (clk),
        .reset  (reset),
        .HoldEn (HoldEn),
        .strobe (strobe),
        .pix    (pix),
        .busy   (busy),
        .done   (done)
    );

    assign out_valid = (count != 2'd0);
    assign push      = strobe;
    assign pop       = out_valid && out_ready;
    assign dropEvt   = push && !pop && (count == 2'd2);

    // Head entry drives the outputs directly and keeps its value once
    // popped; the skid entry only backs it up when two are held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HoldOut   <= '0;
            out_pixel <= '0;
            skidData  <= '0;
            skidPix   <= '0;
            count     <= 2'd0;
        end else if (push && pop) begin
            if (count == 2'd2) begin
                HoldOut   <= skidData;
                out_pixel <= skidPix;
                skidData  <= ShiftIn;
                skidPix   <= pix;
            end else begin
                HoldOut   <= ShiftIn;
                out_pixel <= pix;
            end
        end else if (push) begin
            if (count == 2'd0) begin
                HoldOut   <= ShiftIn;
                out_pixel <= pix;
                count     <= 2'd1;
            end else if (count == 2'd1) begin
                skidData <= ShiftIn;
                skidPix  <= pix;
                count    <= 2'd2;
            end
        end else if (pop) begin
            if (count == 2'd2) begin
                HoldOut   <= skidData;
                out_pixel <= skidPix;
            end
            count <= count - 2'd1;
        end
    end

    // Sticky overrun; a fresh drop wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (dropEvt) begin
            overrun <= 1'b1;
        end else if (clear_ovf) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: doc/gaus_window_hold.md
Name: gaus_window_hold

Overview:
- Parametrised successor to the 5x40-bit hold stage of the gaussian buffer path. It captures a ROWS x ROWW window from the shift buffers on a beat-counter strobe and presents it downstream.
- Adds a valid/ready output handshake, a 2-entry hold queue (main + skid), a captured pixel address per window, an explicit DONE state, and a sticky overrun flag.
- Sits between the shift-buffer block and the gaussian kernel stage.

Parameters:
- ROWS, 5, number of window rows (min 1)
- ROWW, 40, bits per row
- STARTADDRESS, 770, first pixel address captured
- ENDADDRESS, 2097152, pixel address at or beyond which the frame ends
- BEATS, 4, cycles per capture beat (min 1)
- PAUSE, 1, wait cycles after start before beat counting (0 allowed)
- COUNTSTEP, 2, pixel address increment per capture
- PIXW, 24, pixel address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- HoldEn  in  1  run enable; a rising level in IDLE starts a frame, low in RUN freezes the beat phase
- ShiftIn  in  ROWS*ROWW  flattened rows; row 0 (old A) in the LSBs
- HoldOut  out  ROWS*ROWW  head-of-queue window
- out_valid  out  1  HoldOut/out_pixel valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_pixel  out  PIXW  pixel address of the head window
- busy  out  1  state is WAIT or RUN
- done  out  1  high in DONE
- overrun  out  1  sticky; a window was dropped
- clear_ovf  in  1  synchronous clear of overrun

Behaviour:
- Reset values: HoldOut=0, out_valid=0, out_pixel=0, busy=0, done=0, overrun=0. Queue empty, state IDLE, phase=0, pix=STARTADDRESS.
- Reset mid-frame aborts immediately. Queued windows are discarded.
- FSM:
  - IDLE: when HoldEn=1, go to WAIT (or to RUN if PAUSE=0) and load pix=STARTADDRESS.
  - WAIT: count PAUSE cycles, then go to RUN with phase=0.
  - RUN: phase increments 0..BEATS-1 and wraps, advancing only while HoldEn=1.
    - strobe = RUN & HoldEn & phase==BEATS-1.
    - On strobe, capture ShiftIn with tag pix, then pix <= pix+COUNTSTEP (PIXW-bit wrap).
    - If pix+COUNTSTEP >= ENDADDRESS (compare at PIXW+1 bits), go to DONE.
  - DONE: stays until HoldEn=0, then returns to IDLE. The queue still drains in DONE and IDLE.
- Capture latency: a window sampled at the strobe edge appears on HoldOut with out_valid=1 on the next cycle if the queue was empty.
- Queue (depth 2, FIFO order):
  - Pop on out_valid & out_ready. Push on strobe.
  - Push and pop in the same cycle: count is unchanged; the head advances and the new entry enters at the tail.
  - Push into a full queue without a same-cycle pop: the window is dropped, overrun is set, and pix still advances.
- HoldOut and out_pixel hold stable while out_valid & !out_ready.
- clear_ovf together with a new overrun event in the same cycle leaves overrun=1.
- HoldOut holds the last popped value when empty. It is not zeroed, except by reset.

Decomposition:
- Shared package gaus_pkg: state encoding (IDLE, WAIT, RUN, DONE), default STARTADDRESS/ENDADDRESS/PIXW constants, and a function for flattened row slice offsets.
- Sub-module window_beat_counter: implements PAUSE/phase/pix/state and outputs strobe, pix, busy and done. Its behaviour is the beat-counter behaviour above, extended with DONE.
- The top level holds the 2-entry queue, handshake and overrun logic.

Test Plan:
- Reset: assert reset asynchronously mid-RUN with 1 window queued -> all outputs 0 within the same cycle; state IDLE after release.
- Basic frame, ENDADDRESS=776, out_ready=1, HoldEn high at cycle 0:
  - windows appear at out_pixel 770, 772, 774, each 1 cycle after its strobe (strobes 4 cycles apart);
  - done asserts after the 774 capture; exactly 3 windows total.
- Row mapping, ROWS=3, ROWW=8, ShiftIn=0x0A0B0C at a strobe -> HoldOut=0x0A0B0C; row 0 = 0x0C.
- Backpressure, out_ready=0 through 3 strobes:
  - the first two windows (770, 772) are retained in order and overrun=1 after the third;
  - raising out_ready pops 770 then 772.
- HoldEn low for 5 cycles at phase 2 in RUN -> no strobe during the gap; the next strobe comes 1 active cycle after HoldEn returns high.
- PAUSE=0, BEATS=1 -> strobe every cycle from the cycle after start; simultaneous push/pop with out_ready=1 keeps the count at 1 and never sets overrun.
